// File: rtl/hex_digit_counter.sv
// Four-digit hex up/down counter with a selectable-rate divider; each count
// nibble feeds one 7-segment hex decoder (count_o[3:0] = HEX0).
module hex_digit_counter #(
    parameter int DIV_BASE = 50_000_000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        up_i,
    input  logic [1:0]  speed_i,
    input  logic        load_i,
    input  logic [15:0] load_value_i,
    output logic [15:0] count_o,
    output logic        tick_o,
    output logic        wrap_o
);

    localparam int RD_W = ($clog2(4 * DIV_BASE) < 1) ? 1 : $clog2(4 * DIV_BASE);

    localparam logic [RD_W-1:0] RELOAD_00 = '0;
    localparam logic [RD_W-1:0] RELOAD_01 = RD_W'(DIV_BASE - 1);
    localparam logic [RD_W-1:0] RELOAD_10 = RD_W'(2 * DIV_BASE - 1);
    localparam logic [RD_W-1:0] RELOAD_11 = RD_W'(4 * DIV_BASE - 1);

    logic [15:0]     count_q, count_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            tick_q, tick_d;
    logic            wrap_q, wrap_d;
    logic [1:0]      speed_q;
    logic            speed_valid_q;
    logic [RD_W-1:0] reload;
    logic            speed_chg;

    always_comb begin
        reload = RELOAD_00;
        case (speed_i)
            2'b00: reload = RELOAD_00;
            2'b01: reload = RELOAD_01;
            2'b10: reload = RELOAD_10;
            2'b11: reload = RELOAD_11;
            default: reload = RELOAD_00;
        endcase
    end

    // After reset there is no previous speed, so the first edge behaves as a
    // speed change and primes the divider with the rate then selected.
    assign speed_chg = !speed_valid_q || (speed_i != speed_q);

    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (load_i) begin
            count_d = load_value_i;
            rd_d    = reload;
        end else if (speed_chg) begin
            rd_d = reload;
        end else if (enable_i) begin
            if (rd_q == '0) begin
                count_d = up_i ? (count_q + 16'd1) : (count_q - 16'd1);
                rd_d    = reload;
                tick_d  = 1'b1;
                wrap_d  = up_i ? (&count_q) : (~|count_q);
            end else begin
                rd_d = rd_q - RD_W'(1);
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q       <= '0;
            rd_q          <= '0;
            tick_q        <= 1'b0;
            wrap_q        <= 1'b0;
            speed_q       <= 2'b00;
            speed_valid_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            rd_q          <= rd_d;
            tick_q        <= tick_d;
            wrap_q        <= wrap_d;
            speed_q       <= speed_i;
            speed_valid_q <= 1'b1;
        end
    end

    assign count_o = count_q;
    assign tick_o  = tick_q;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_hex_digit_counter.sv
// Directed-vector bench for hex_digit_counter with DIV_BASE=4 (periods 1/4/8/16).
module tb_hex_digit_counter;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        up;
    logic [1:0]  speed;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] count;
    logic        tick;
    logic        wrap;

    int vectors = 0;
    int miscompares = 0;

    hex_digit_counter #(.DIV_BASE(4)) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .enable_i     (enable),
        .up_i         (up),
        .speed_i      (speed),
        .load_i       (load),
        .load_value_i (load_value),
        .count_o      (count),
        .tick_o       (tick),
        .wrap_o       (wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Check count, tick and wrap together after one more edge.
    task automatic step_chk(input string tag, input logic [15:0] c, input logic t, input logic w);
        step();
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".tick"},  32'(tick),  32'(t));
        chk({tag, ".wrap"},  32'(wrap),  32'(w));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; up = 1'b1; speed = 2'b01;
        load = 1'b0; load_value = 16'h0000;
        step(); step();
        chk("rst.count", 32'(count), 32'h0);
        chk("rst.tick",  32'(tick),  32'h0);
        chk("rst.wrap",  32'(wrap),  32'h0);

        // Run up to the first count, then pulse reset between edges
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step_chk("boot.wait", 16'h0000, 1'b0, 1'b0);
        step_chk("boot.first", 16'h0001, 1'b1, 1'b0);
        step(); step();
        #2 reset = 1'b1;
        #1;
        chk("async.count", 32'(count), 32'h0);
        chk("async.tick",  32'(tick),  32'h0);
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) step_chk("rel.wait", 16'h0000, 1'b0, 1'b0);
        step_chk("rel.first", 16'h0001, 1'b1, 1'b0);

        // speed 00 wrap upward
        speed = 2'b00; load = 1'b1; load_value = 16'hFFFE;
        step_chk("up.load", 16'hFFFE, 1'b0, 1'b0);
        load = 1'b0;
        step_chk("up.c1", 16'hFFFF, 1'b1, 1'b0);
        step_chk("up.c2", 16'h0000, 1'b1, 1'b1);
        step_chk("up.c3", 16'h0001, 1'b1, 1'b0);

        // speed 11 counting down through zero
        speed = 2'b11; up = 1'b0; load = 1'b1; load_value = 16'h0001;
        step_chk("dn.load", 16'h0001, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 15; i++) step_chk("dn.wait1", 16'h0001, 1'b0, 1'b0);
        step_chk("dn.c1", 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step_chk("dn.wait2", 16'h0000, 1'b0, 1'b0);
        step_chk("dn.c2", 16'hFFFF, 1'b1, 1'b1);

        // enable dropped mid-period
        speed = 2'b01; up = 1'b1; load = 1'b1; load_value = 16'h0100;
        step_chk("en.load", 16'h0100, 1'b0, 1'b0);
        load = 1'b0;
        step(); step();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) step_chk("en.frozen", 16'h0100, 1'b0, 1'b0);
        enable = 1'b1;
        step_chk("en.resume1", 16'h0100, 1'b0, 1'b0);
        step_chk("en.resume2", 16'h0101, 1'b1, 1'b0);

        // load in the very cycle the divider reaches zero
        step(); step(); step();
        load = 1'b1; load_value = 16'h1234;
        step_chk("ld0.load", 16'h1234, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 3; i++) step_chk("ld0.wait", 16'h1234, 1'b0, 1'b0);
        step_chk("ld0.next", 16'h1235, 1'b1, 1'b0);

        // speed 01 -> 10 mid-period restarts the divider with the longer period
        step();
        speed = 2'b10;
        step_chk("spd.switch", 16'h1235, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step_chk("spd.wait", 16'h1235, 1'b0, 1'b0);
        step_chk("spd.next", 16'h1236, 1'b1, 1'b0);

        // up changes between count edges at full rate
        speed = 2'b00; load = 1'b1; load_value = 16'h0010;
        step_chk("dir.load", 16'h0010, 1'b0, 1'b0);
        load = 1'b0; up = 1'b0;
        step_chk("dir.down", 16'h000F, 1'b1, 1'b0);
        up = 1'b1;
        step_chk("dir.up", 16'h0010, 1'b1, 1'b0);

        // load still applies while disabled
        enable = 1'b0; load = 1'b1; load_value = 16'hABCD;
        step_chk("dis.load", 16'hABCD, 1'b0, 1'b0);
        load = 1'b0;
        step_chk("dis.hold", 16'hABCD, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
